// File: rtl/mon_serial_rx_pkg.sv
// Shared nextasic definitions for the monitor serial receiver: FSM encodings and link timing.
package mon_serial_rx_pkg;

   localparam int unsigned MON_BIT_CLKS = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/mon_bit_timer.sv
// Bit-period timer: saturating counter with synchronous clear and registered half/full terminal flags.
module mon_bit_timer
   import mon_serial_rx_pkg::*;
#(
   parameter int unsigned BIT_CLKS = MON_BIT_CLKS,
   parameter int unsigned CNT_W    = 5
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   output logic half_o,
   output logic full_o
);

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_CLKS / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BIT_CLKS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             half_q, full_q;

   // Holds at FULL_CNT rather than wrapping; the FSM always clears before reuse.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != FULL_CNT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Flags are decoded from the next count so they line up with cnt_q.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         half_q <= 1'b0;
         full_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= (cnt_d == HALF_CNT);
         full_q <= (cnt_d == FULL_CNT);
      end
   end

   assign half_o = half_q;
   assign full_o = full_q;

endmodule

// File: rtl/mon_serial_rx.sv
// NeXT monitor serial receiver: start/stop frame deserialiser with valid/ready holding register.
module mon_serial_rx
   import mon_serial_rx_pkg::*;
#(
   parameter int unsigned DATA_W   = 40,
   parameter int unsigned BIT_CLKS = MON_BIT_CLKS,
   parameter int unsigned CNT_W    = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_serial,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned       BCNT_W   = $clog2(DATA_W + 1);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

   rx_state_e         state_q, state_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
   logic              ovr_q, ovr_d;
   logic              tmr_clr_c, tmr_half, tmr_full;

   mon_bit_timer #(
      .BIT_CLKS (BIT_CLKS),
      .CNT_W    (CNT_W)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (tmr_clr_c),
      .half_o  (tmr_half),
      .full_o  (tmr_full)
   );

   // Next-state, shift and holding-register logic.
   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      tmr_clr_c = 1'b0;

      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            tmr_clr_c = 1'b1;
            if (!in_serial) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tmr_half) begin
               tmr_clr_c = 1'b1;
               if (!in_serial) begin
                  state_d = ST_DATA;
                  bcnt_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (tmr_full) begin
               tmr_clr_c = 1'b1;
               shift_d   = {shift_q[DATA_W-2:0], in_serial};
               bcnt_d    = bcnt_q + BCNT_W'(1);
               if (bcnt_q == LAST_BIT) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (tmr_full) begin
               tmr_clr_c = 1'b1;
               if (in_serial) begin
                  state_d = ST_IDLE;
                  // A frame accepted on this same edge frees the register for the new one.
                  if (!valid_q || out_ready) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            tmr_clr_c = 1'b1;
            if (in_serial) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         bcnt_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_mon_serial_rx.sv
// Directed bench for mon_serial_rx with DATA_W=8, BIT_CLKS=8.
module tb_mon_serial_rx;

   localparam int unsigned DW = 8;
   localparam int unsigned BC = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_serial;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          frame_err;
   logic          overrun;

   int n_chk = 0;
   int n_bad = 0;

   int cyc = 0;
   int t0_cyc = 0;
   int last_acc_edge = 0;
   int valid_hi_cnt = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   logic [DW-1:0] acc_q[$];

   mon_serial_rx #(
      .DATA_W   (DW),
      .BIT_CLKS (BC),
      .CNT_W    (3)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_serial (in_serial),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs mid-cycle; a valid&&ready seen here is taken at the next edge (cyc+1).
   always @(negedge clk) begin
      if (out_valid) valid_hi_cnt++;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
         acc_q.push_back(out_data);
         last_acc_edge = cyc + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_acc(input string tag, input logic [DW-1:0] exp);
      chk({tag, "_cnt"}, 64'(acc_q.size()), 64'(1));
      if (acc_q.size() > 0) chk({tag, "_data"}, 64'(acc_q.pop_front()), 64'(exp));
   endtask

   // Drives start, data MSB first, then stop; the line is left at the stop value.
   task automatic send_frame(input logic [DW-1:0] d, input logic stop_b);
      logic [DW+1:0] fb;
      fb = {1'b0, d, stop_b};
      @(posedge clk);
      #1;
      t0_cyc = cyc + 1;
      for (int i = DW + 1; i >= 0; i--) begin
         in_serial = fb[i];
         repeat (BC) @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   int v0, f0, o0;

   initial begin
      reset_n   = 1'b0;
      in_serial = 1'b1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_ferr", 64'(frame_err), 64'(0));
      chk("rst_ovr", 64'(overrun), 64'(0));
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic frame, consumer always ready.
      out_ready = 1'b1;
      v0 = valid_hi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'hA5, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      expect_acc("a5", 8'hA5);
      chk("a5_take_edge", 64'(last_acc_edge - t0_cyc), 64'(77));
      chk("a5_valid_cycles", 64'(valid_hi_cnt - v0), 64'(1));
      chk("a5_ferr", 64'(ferr_cnt - f0), 64'(0));
      chk("a5_ovr", 64'(ovr_cnt - o0), 64'(0));

      // Short low glitch must not start a frame.
      v0 = valid_hi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      in_serial = 1'b0;
      repeat (3) @(posedge clk);
      #1 in_serial = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("glitch_valid", 64'(valid_hi_cnt - v0), 64'(0));
      chk("glitch_ferr", 64'(ferr_cnt - f0), 64'(0));
      chk("glitch_acc", 64'(acc_q.size()), 64'(0));
      send_frame(8'h3C, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      expect_acc("3c", 8'h3C);

      // Bad stop bit, then line held low (break).
      v0 = valid_hi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h81, 1'b0);
      repeat (20) @(posedge clk);
      #1 in_serial = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("brk_ferr", 64'(ferr_cnt - f0), 64'(1));
      chk("brk_valid", 64'(valid_hi_cnt - v0), 64'(0));
      chk("brk_ovr", 64'(ovr_cnt - o0), 64'(0));
      chk("brk_acc", 64'(acc_q.size()), 64'(0));
      send_frame(8'h7E, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      expect_acc("7e", 8'h7E);

      // Overrun: two frames back-to-back into a full register.
      out_ready = 1'b0;
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("ovr_valid", 64'(out_valid), 64'(1));
      chk("ovr_held_data", 64'(out_data), 64'(8'h11));
      chk("ovr_pulses", 64'(ovr_cnt - o0), 64'(1));
      drain();
      chk("ovr_drain_valid", 64'(out_valid), 64'(0));
      expect_acc("ovr_drain", 8'h11);

      // Consumer takes the held frame on the same edge a new one lands.
      send_frame(8'h11, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      o0 = ovr_cnt;
      fork
         send_frame(8'h22, 1'b1);
         begin
            @(posedge clk);
            #1;
            repeat (76) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
         end
      join
      #1;
      chk("swap_valid", 64'(out_valid), 64'(1));
      chk("swap_data", 64'(out_data), 64'(8'h22));
      chk("swap_ovr", 64'(ovr_cnt - o0), 64'(0));
      expect_acc("swap_old", 8'h11);
      drain();
      chk("swap_drain_valid", 64'(out_valid), 64'(0));
      expect_acc("swap_new", 8'h22);

      // Asynchronous reset mid-data with a frame held.
      send_frame(8'h33, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_valid", 64'(out_valid), 64'(1));
      f0 = ferr_cnt;
      fork
         send_frame(8'hFF, 1'b1);
         begin
            @(posedge clk);
            #1;
            repeat (30) @(posedge clk);
            #3 reset_n = 1'b0;
            #1;
            chk("arst_valid", 64'(out_valid), 64'(0));
            chk("arst_data", 64'(out_data), 64'(0));
            chk("arst_ferr", 64'(frame_err), 64'(0));
            chk("arst_ovr", 64'(overrun), 64'(0));
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("arst_nofr", 64'(acc_q.size()), 64'(0));
      chk("arst_noerr", 64'(ferr_cnt - f0), 64'(0));
      out_ready = 1'b1;
      send_frame(8'h5A, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      expect_acc("5a", 8'h5A);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
